// File: rtl/md_writeback_scheduler.sv
// -----------------------------------------------------------------------------
// md_writeback_scheduler
//
// Purpose:
//   Sequences the multdiv unit from the X stage. Gates start pulses, tracks the
//   single in-flight op and its destination register, stalls the pipeline until
//   the result is written back, and shares the one regfile write port between
//   the W-stage writeback and the multdiv result. The W stage always wins; a
//   colliding multdiv result is held and written on the first free cycle.
//
// Ports:
//   clock, reset                    rising-edge clock, synchronous active-high reset
//   issue_mult, issue_div, issue_rd X-stage op request pulses and destination
//   md_ready, md_exception,         multdiv result handshake, exception flag, data
//   md_result
//   w_we, w_rd, w_data              W-stage write request
//   md_start_mult, md_start_div     start strobes to multdiv
//   rf_we, rf_rd, rf_data           shared regfile write port
//   stall_req                       freeze PC/FD/DX and inject a nop
//   hazard_valid, hazard_rd         destination still awaiting its multdiv write
//   protocol_err, timeout_err       sticky error flags
//
// Configuration:
//   MD_EXCEPTION_STATUS_EN - when defined, a multdiv exception redirects the
//   writeback to STATUS_REG with MULT_EXC_CODE / DIV_EXC_CODE as data. When
//   undefined, md_exception is ignored and md_result always goes to issue_rd.
// -----------------------------------------------------------------------------
module md_writeback_scheduler #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned STATUS_REG     = 30,
    parameter int unsigned MULT_EXC_CODE  = 4,
    parameter int unsigned DIV_EXC_CODE   = 5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        issue_mult,
    input  logic        issue_div,
    input  logic [4:0]  issue_rd,
    input  logic        md_ready,
    input  logic        md_exception,
    input  logic [31:0] md_result,
    input  logic        w_we,
    input  logic [4:0]  w_rd,
    input  logic [31:0] w_data,
    output logic        md_start_mult,
    output logic        md_start_div,
    output logic        rf_we,
    output logic [4:0]  rf_rd,
    output logic [31:0] rf_data,
    output logic        stall_req,
    output logic        hazard_valid,
    output logic [4:0]  hazard_rd,
    output logic        protocol_err,
    output logic        timeout_err
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StWb
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [4:0]        rd_q, rd_d;
    logic [31:0]       data_q, data_d;
    logic              op_div_q, op_div_d;
    logic              perr_q, perr_d;
    logic              terr_q, terr_d;

    logic              any_issue;
    logic              legal_issue;

    assign any_issue   = issue_mult | issue_div;
    assign legal_issue = issue_mult ^ issue_div;

`ifndef MD_EXCEPTION_STATUS_EN
    // Exception handling is compiled out; keep these inputs/params visibly consumed.
    logic unused_cfg;
    assign unused_cfg = ^{md_exception, op_div_q, 5'(STATUS_REG), 32'(MULT_EXC_CODE),
                          32'(DIV_EXC_CODE)};
`endif

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rd_d     = rd_q;
        data_d   = data_q;
        op_div_d = op_div_q;
        perr_d   = perr_q;
        terr_d   = terr_q;

        case (state_q)
            StIdle: begin
                if (legal_issue) begin
                    rd_d     = issue_rd;
                    op_div_d = issue_div;
                    cnt_d    = '0;
                    state_d  = StRun;
                end else if (any_issue) begin
                    perr_d = 1'b1;
                end
            end

            StRun: begin
                if (any_issue) begin
                    perr_d = 1'b1;
                end
                if (md_ready) begin
                    data_d  = md_result;
                    state_d = StWb;
`ifdef MD_EXCEPTION_STATUS_EN
                    if (md_exception) begin
                        rd_d   = 5'(STATUS_REG);
                        data_d = op_div_q ? 32'(DIV_EXC_CODE) : 32'(MULT_EXC_CODE);
                    end
`endif
                end else if (cnt_q == CntMax) begin
                    // Op abandoned; nothing will be written for it.
                    state_d = StIdle;
                    terr_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end

            StWb: begin
                if (any_issue) begin
                    perr_d = 1'b1;
                end
                if (!w_we) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            rd_q     <= '0;
            data_q   <= '0;
            op_div_q <= 1'b0;
            perr_q   <= 1'b0;
            terr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rd_q     <= rd_d;
            data_q   <= data_d;
            op_div_q <= op_div_d;
            perr_q   <= perr_d;
            terr_q   <= terr_d;
        end
    end

    // Outputs. Start strobes and the regfile pass-through are combinational so the
    // multdiv sees its start in the issue cycle and W-stage writes are not delayed.
    always_comb begin
        md_start_mult = 1'b0;
        md_start_div  = 1'b0;
        rf_we         = w_we;
        rf_rd         = w_rd;
        rf_data       = w_data;
        stall_req     = 1'b0;
        hazard_valid  = 1'b0;
        hazard_rd     = 5'd0;
        protocol_err  = perr_q;
        timeout_err   = terr_q;

        case (state_q)
            StIdle: begin
                md_start_mult = legal_issue & issue_mult;
                md_start_div  = legal_issue & issue_div;
                stall_req     = legal_issue;
            end

            StRun: begin
                stall_req    = 1'b1;
                hazard_valid = 1'b1;
                hazard_rd    = rd_q;
`ifdef MD_EXCEPTION_STATUS_EN
                // Exception redirects the pending write as soon as it is reported.
                if (md_ready && md_exception) begin
                    hazard_rd = 5'(STATUS_REG);
                end
`endif
            end

            StWb: begin
                stall_req    = 1'b1;
                hazard_valid = 1'b1;
                hazard_rd    = rd_q;
                if (!w_we) begin
                    rf_we   = (rd_q != 5'd0);
                    rf_rd   = rd_q;
                    rf_data = data_q;
                end
            end

            default: begin
                stall_req = 1'b0;
            end
        endcase

        // Everything is quiet while reset is asserted, including the pass-through.
        if (reset) begin
            md_start_mult = 1'b0;
            md_start_div  = 1'b0;
            rf_we         = 1'b0;
            rf_rd         = 5'd0;
            rf_data       = 32'd0;
            stall_req     = 1'b0;
            hazard_valid  = 1'b0;
            hazard_rd     = 5'd0;
            protocol_err  = 1'b0;
            timeout_err   = 1'b0;
        end
    end

endmodule
